enigma_pipe: RTL
================

ENIGMA_PIPE -- requirements
Module: enigma_pipe

Interface
REQ-001 Parameter NUM_ROTORS, default 3, number of cascaded rotors; legal range 1..4.
REQ-002 Parameter SYM_W, default 5, symbol width in bits.
REQ-003 Parameter ALPHA, default 26, alphabet size; ALPHA <= 2**SYM_W.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 cfg_load  in  1  load start positions from cfg_pos.
REQ-007 cfg_pos  in  NUM_ROTORS*SYM_W  start positions; slice k is rotor k, rotor 0 rightmost/entry.
REQ-008 in_valid / in_ready  in / out  1  input handshake.
REQ-009 in_sym  in  SYM_W  plaintext or ciphertext symbol.
REQ-010 out_valid / out_ready  out / in  1  output handshake.
REQ-011 out_sym  out  SYM_W  result symbol.
REQ-012 pos  out  NUM_ROTORS*SYM_W  current rotor positions.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 cfg_err  out  1  one-cycle pulse when cfg_load is ignored.

Function
REQ-015 FSM states: IDLE, STEP, FWD, REFL, BWD, HOLD.
- IDLE: in_ready=1.
- Accept (in_valid & in_ready) -> STEP.
- STEP -> FWD.
- FWD: NUM_ROTORS cycles, rotor index k=0..N-1 -> REFL.
- REFL -> BWD.
- BWD: NUM_ROTORS cycles, k=N-1..0 -> HOLD.
- HOLD: out_valid=1; on out_ready -> IDLE.
REQ-016 Latency: out_valid asserts 2*NUM_ROTORS+2 cycles after the accept edge; default config gives 8.
REQ-017 in_ready is high only in IDLE; at most one symbol is in flight.
REQ-018 out_sym and out_valid are held stable in HOLD until out_ready.
REQ-019 STEP rules:
- Rotor 0 advances by one.
- Rotor k+1 advances when rotor k is at its notch before the step.
- Double-step: rotor k, for 1 <= k <= N-2, also advances when it is itself at its notch.
- All rotors update simultaneously.
REQ-020 Position wrap: ALPHA-1 -> 0.
REQ-021 Forward through rotor k: x' = (W_k[(x+p_k) mod ALPHA] - p_k) mod ALPHA.
REQ-022 Backward through rotor k uses the same formula with the inverse table Winv_k.
REQ-023 Reflector applies the fixed table R.
REQ-024 Modular add/subtract uses SYM_W+1-bit intermediates with a single conditional correction by ALPHA.
REQ-025 in_sym >= ALPHA:
- Treated as pass-through: no rotor step.
- out_sym = in_sym, with the same latency and handshake.
REQ-026 cfg_load in IDLE with no simultaneous accept loads pos from cfg_pos on the next edge; values >= ALPHA are reduced mod ALPHA.
REQ-027 cfg_load in IDLE takes priority over in_valid; in_ready is low that cycle.
REQ-028 cfg_load outside IDLE is ignored and pulses cfg_err.

Reset
REQ-029 rst_n low asynchronously forces:
- state=IDLE
- pos=0
- out_valid=0
- out_sym=0
- cfg_err=0
- busy=0
- plugboard = identity (when PLUGBOARD_EN)
REQ-030 Reset mid-operation discards the in-flight symbol without producing output.
REQ-031 in_ready=1 from the first edge after rst_n deasserts.

Configuration
REQ-032 Macro ENIGMA_PLUGBOARD_EN defined:
- Adds inputs plug_wr (1), plug_a (SYM_W), plug_b (SYM_W).
- plug_wr in IDLE swaps the entries a<->b in a 26-entry plugboard register.
- The plugboard is applied in STEP (before FWD) and on the exit of BWD (before HOLD); latency is unchanged.
- plug_wr outside IDLE is ignored.
REQ-033 Macro ENIGMA_PLUGBOARD_EN undefined: no plug ports, identity mapping, no plugboard registers.

Structure
REQ-034 Package enigma_pkg holds:
- ROTOR_W and ROTOR_WINV: tables for rotors III, II, I, IV, indexed by rotor k.
- ROTOR_NOTCH = {V, E, Q, J}.
- REFL_B table.
- State enum typedef.
- Modular add/sub functions.
REQ-035 One sub-module, enigma_rotor_stage: combinational single-rotor map (table select k, position, direction), time-shared by FWD and BWD.

Verification
REQ-036 Reset, then in_sym 0,0,0,0,0 (AAAAA) -> out 1,3,25,6,14 (BDZGO); pos ends at {0,0,5}.
REQ-037 Reciprocity: cfg_load 0,0,0; feed BDZGO -> out AAAAA.
REQ-038 Double-step: cfg_pos left..right A,D,U; three symbols -> pos A,D,V then A,E,W then B,F,X.
REQ-039 Backpressure: out_ready low 5 cycles in HOLD -> out_sym stable, in_ready=0, no extra step; single output on release.
REQ-040 in_sym=31 -> out_sym=31 after 8 cycles, pos unchanged; cfg_load while busy -> cfg_err pulse, pos unchanged.
REQ-041 rst_n pulsed during FWD -> no out_valid, pos=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared Enigma constants: rotor/reflector wirings, notches, FSM state type and
// modular arithmetic helpers used by enigma_rotor_stage and enigma_pipe.
package enigma_pkg;

    localparam int TBL_LEN    = 26;
    localparam int MAX_ROTORS = 4;

    typedef logic [TBL_LEN*8-1:0] tbl_t;

    // ASCII wirings; the first character is the image of 'A'. Index k = 0 is the entry rotor.
    localparam tbl_t ROTOR_W [MAX_ROTORS] = '{
        "BDFHJLCPRTXVZNYEIWGAKMUSQO",   // III
        "AJDKSIRUXBLHWTMCQGZNPYFVOE",   // II
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ",   // I
        "ESOVPZJAYQUIRHXLNFTGKDCMWB"    // IV
    };

    localparam tbl_t ROTOR_WINV [MAX_ROTORS] = '{
        "TAGBPCSDQEUFVNZHYIXJWLRKOM",
        "AJPCZWRLFBDKOTYUQGENHXMIVS",
        "UWYGADFPVZBECKMTHXSLRINQOJ",
        "HZWVARTNLGUPXQCEJMBSKDYOIF"
    };

    // Notch letters V, E, Q, J for rotors III, II, I, IV.
    localparam logic [4:0] ROTOR_NOTCH [MAX_ROTORS] = '{5'd21, 5'd4, 5'd16, 5'd9};

    localparam tbl_t REFL_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        FWD,
        REFL,
        BWD,
        HOLD
    } state_t;

    function automatic logic [7:0] tbl_lookup(input tbl_t t, input logic [7:0] i);
        if (int'(i) >= TBL_LEN) return i;
        return t[(TBL_LEN - 1 - int'(i))*8 +: 8] - 8'd65;
    endfunction

    // Operands are already reduced, so one conditional correction by m suffices.
    function automatic logic [7:0] mod_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] m);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[7:0];
    endfunction

    function automatic logic [7:0] mod_sub(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] m);
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[8]) d = d + {1'b0, m};
        return d[7:0];
    endfunction

endpackage

// File: rtl/enigma_rotor_stage.sv
// Combinational single-rotor map: x' = (W_k[(x+p) mod ALPHA] - p) mod ALPHA,
// using the inverse table when bwd is set. Shared by the forward and backward passes.
module enigma_rotor_stage
    import enigma_pkg::*;
#(
    parameter int SYM_W = 5,
    parameter int ALPHA = 26
) (
    input  logic [1:0]       k,
    input  logic [SYM_W-1:0] p,
    input  logic [SYM_W-1:0] x,
    input  logic             bwd,
    output logic [SYM_W-1:0] y
);

    logic [7:0] entry;
    logic [7:0] wired;

    always_comb begin
        entry = mod_add(8'(x), 8'(p), 8'(ALPHA));
        wired = tbl_lookup(bwd ? ROTOR_WINV[k] : ROTOR_W[k], entry);
        y     = SYM_W'(mod_sub(wired, 8'(p), 8'(ALPHA)));
    end

endmodule

// File: rtl/enigma_pipe.sv
// Multi-cycle Enigma encipher/decipher engine: one symbol in flight, rotors stepped
// before each symbol. Optional plugboard enabled by defining ENIGMA_PLUGBOARD_EN.
module enigma_pipe
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS = 3,
    parameter int SYM_W      = 5,
    parameter int ALPHA      = 26
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_load,
    input  logic [NUM_ROTORS*SYM_W-1:0] cfg_pos,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SYM_W-1:0]            in_sym,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SYM_W-1:0]            out_sym,
    output logic [NUM_ROTORS*SYM_W-1:0] pos,
    output logic                        busy,
    output logic                        cfg_err
`ifdef ENIGMA_PLUGBOARD_EN
    ,
    input  logic                        plug_wr,
    input  logic [SYM_W-1:0]            plug_a,
    input  logic [SYM_W-1:0]            plug_b
`endif
);

    localparam logic [1:0] K_LAST = 2'(NUM_ROTORS - 1);

    state_t                             state;
    state_t                             state_d;
    logic [1:0]                         k;
    logic [NUM_ROTORS-1:0][SYM_W-1:0]   pos_q;
    logic [NUM_ROTORS-1:0][SYM_W-1:0]   stepped;
    logic [NUM_ROTORS-1:0][SYM_W-1:0]   cfg_mod;
    logic [NUM_ROTORS:0]                carry;
    logic [NUM_ROTORS-1:0]              at_notch;
    logic [SYM_W-1:0]                   sym;
    logic                               bypass;
    logic [SYM_W-1:0]                   stage_p;
    logic [SYM_W-1:0]                   stage_y;
    logic [SYM_W-1:0]                   refl_y;
    logic [SYM_W-1:0]                   plug_fwd;
    logic [SYM_W-1:0]                   plug_out;

    assign in_ready  = (state == IDLE) && !cfg_load;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign pos       = pos_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d = state;
        case (state)
            IDLE:    if (!cfg_load && in_valid) state_d = STEP;
            STEP:    state_d = FWD;
            FWD:     if (k == K_LAST) state_d = REFL;
            REFL:    state_d = BWD;
            BWD:     if (k == 2'd0) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Rotor k+1 is carried by rotor k's notch; middle rotors also kick themselves (double step).
    always_comb begin
        carry[0] = 1'b1;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            at_notch[i]  = (pos_q[i] == SYM_W'(ROTOR_NOTCH[i]));
            carry[i+1]   = at_notch[i];
            stepped[i]   = pos_q[i];
            cfg_mod[i]   = SYM_W'(int'(cfg_pos[i*SYM_W +: SYM_W]) % ALPHA);
            if (carry[i] || (i >= 1 && i <= NUM_ROTORS - 2 && at_notch[i]))
                stepped[i] = SYM_W'(mod_add(8'(pos_q[i]), 8'd1, 8'(ALPHA)));
        end
    end

    always_comb begin
        stage_p = '0;
        for (int i = 0; i < NUM_ROTORS; i++)
            if (k == 2'(i)) stage_p = pos_q[i];
        refl_y = SYM_W'(tbl_lookup(REFL_B, 8'(sym)));
    end

    enigma_rotor_stage #(
        .SYM_W (SYM_W),
        .ALPHA (ALPHA)
    ) u_stage (
        .k   (k),
        .p   (stage_p),
        .x   (sym),
        .bwd (state == BWD),
        .y   (stage_y)
    );

`ifdef ENIGMA_PLUGBOARD_EN
    logic [SYM_W-1:0] plug [TBL_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small register file is reset to identity; a true RAM would not be reset.
            for (int i = 0; i < TBL_LEN; i++) plug[i] <= SYM_W'(i);
        end else if (state == IDLE && plug_wr &&
                     int'(plug_a) < TBL_LEN && int'(plug_b) < TBL_LEN) begin
            plug[plug_a] <= plug[plug_b];
            plug[plug_b] <= plug[plug_a];
        end
    end

    always_comb begin
        plug_fwd = sym;
        plug_out = stage_y;
        if (int'(sym) < TBL_LEN)     plug_fwd = plug[sym];
        if (int'(stage_y) < TBL_LEN) plug_out = plug[stage_y];
    end
`else
    assign plug_fwd = sym;
    assign plug_out = stage_y;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pos_q   <= '0;
            k       <= '0;
            sym     <= '0;
            bypass  <= 1'b0;
            out_sym <= '0;
            cfg_err <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            state   <= state_d;
            cfg_err <= cfg_load && (state != IDLE);
            case (state)
                IDLE: begin
                    if (cfg_load) begin
                        pos_q <= cfg_mod;
                    end else if (in_valid) begin
                        sym    <= in_sym;
                        bypass <= (int'(in_sym) >= ALPHA);
                    end
                end
                STEP: begin
                    k <= '0;
                    if (!bypass) begin
                        pos_q <= stepped;
                        sym   <= plug_fwd;
                    end
                end
                FWD: begin
                    if (!bypass) sym <= stage_y;
                    if (k != K_LAST) k <= k + 2'd1;
                end
                REFL: begin
                    if (!bypass) sym <= refl_y;
                end
                BWD: begin
                    if (!bypass) sym <= stage_y;
                    if (k == 2'd0) out_sym <= bypass ? sym : plug_out;
                    else           k <= k - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
